mem_loader: RTL and testbench

Boot-time loader that sits directly upstream of the data `memory_bank` and drives its write port. It accepts a byte stream with a valid/ready handshake and packs the bytes little-endian into memory words. It writes those words to consecutive addresses starting at a programmed base and reports completion plus an XOR checksum of everything written. The CPU is held off the memory port while `busy` is high; the top-level mux owns that arbitration.

---
 rtl/mem_loader.sv | 72 +++++++
 tb/tb_mem_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: packs a little-endian byte stream into words written to consecutive memory addresses
module mem_loader #(
  parameter int word_size = 16,
  parameter int addr_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addr_size-1:0] base_addr,
  input  logic [addr_size:0]   word_count,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_w_en,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_d_in,
  output logic                 busy,
  output logic                 done,
  output logic [word_size-1:0] checksum
);
  localparam int bpw = word_size / 8;
  localparam int bw = bpw > 1 ? $clog2(bpw) : 1;
  localparam logic [bw-1:0] last = bw'(bpw - 1);
  localparam logic [addr_size:0] one = (addr_size + 1)'(1);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t state, next;
  logic [addr_size-1:0] addr;
  logic [addr_size:0] remaining;
  logic [bw-1:0] byte_idx;
  logic [word_size-1:0] word_buf;
  logic take;
  assign take = in_valid && state == LOAD;
  assign in_ready = state == LOAD;
  assign mem_w_en = state == WRITE;
  assign busy = state == LOAD || state == WRITE;
  assign done = state == DONE;
  assign mem_addr = addr;
  assign mem_d_in = word_buf;
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = IDLE;
    next = state == IDLE  ? (start ? (word_count != '0 ? LOAD : DONE) : IDLE)
         : state == LOAD  ? (take && byte_idx == last ? WRITE : LOAD)
         : state == WRITE ? (remaining == one ? DONE : LOAD)
         : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      checksum  <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
      if (word_count != '0) begin
        addr      <= base_addr;
        remaining <= word_count;
        byte_idx  <= '0;
        word_buf  <= '0;
      end
    end else if (take) begin
      word_buf[{byte_idx, 3'b000} +: 8] <= in_data;
      byte_idx <= byte_idx + bw'(1);
    end else if (state == WRITE) begin
      checksum  <= checksum ^ word_buf;
      addr      <= addr + addr_size'(1);
      remaining <= remaining - one;
      byte_idx  <= '0;
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed self-checking bench for mem_loader with a behavioural memory
module tb_mem_loader;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] base_addr = 0, in_data = 0;
  logic [8:0] word_count = 0;
  logic in_ready, mem_w_en, busy, done;
  logic [7:0] mem_addr;
  logic [15:0] mem_d_in, checksum;
  logic [15:0] mem [256];
  logic [7:0] wa[$];
  logic [15:0] wd[$];
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, done_cyc = 0, busy_seen = 0;

  mem_loader #(.word_size(16), .addr_size(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_w_en) mem[mem_addr] <= mem_d_in;
  end
  always @(negedge clk) begin
    if (mem_w_en) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_d_in);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1;
    base_addr = b;
    word_count = n;
    tick;
    start = 0;
  endtask

  task push(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1;
    in_data = b;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    tick;
    in_valid = 0;
  endtask

  task wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      tick;
      n++;
    end
  endtask

  task test_reset;
    rst = 1;
    tick;
    tick;
    tests++;
    if ({in_ready, mem_w_en, busy, done} !== 4'b0 || mem_addr !== 8'h00 || mem_d_in !== 16'h0 || checksum !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b wen=%b busy=%b done=%b addr=%h d=%h cs=%h exp all zero",
               in_ready, mem_w_en, busy, done, mem_addr, mem_d_in, checksum);
    end
    rst = 0;
    tick;
    tests++;
    if ({in_ready, busy, done} !== 3'b0) begin
      fails++;
      $display("FAIL idle_after_reset got rdy=%b busy=%b done=%b exp 000", in_ready, busy, done);
    end
  endtask

  task test_basic;
    int t0, d0;
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    do_start(8'h10, 9'd2);
    t0 = cyc;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_ready got rdy=%b busy=%b exp 1 1", in_ready, busy);
    end
    push(8'h34);
    push(8'h12);
    push(8'h78);
    push(8'h56);
    wait_done(d0);
    tests++;
    if (done_cyc - t0 !== 6) begin
      fails++;
      $display("FAIL basic_done_latency got %0d exp 6", done_cyc - t0);
    end
    tests++;
    if (wa.size() !== 2) begin
      fails++;
      $display("FAIL basic_write_count got %0d exp 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 8'h10 || wd[0] !== 16'h1234 || wa[1] !== 8'h11 || wd[1] !== 16'h5678) begin
        fails++;
        $display("FAIL basic_writes got %h:%h %h:%h exp 10:1234 11:5678", wa[0], wd[0], wa[1], wd[1]);
      end
    end
    tests++;
    if (checksum !== 16'h444C) begin
      fails++;
      $display("FAIL basic_checksum got %h exp 444c", checksum);
    end
    tick;
    tests++;
    if (mem[8'h10] !== 16'h1234 || mem[8'h11] !== 16'h5678 || done !== 1'b0 || checksum !== 16'h444C) begin
      fails++;
      $display("FAIL basic_readback got %h %h done=%b cs=%h exp 1234 5678 0 444c", mem[8'h10], mem[8'h11], done, checksum);
    end
  endtask

  task test_zero;
    int w0;
    w0 = wa.size();
    busy_seen = 0;
    do_start(8'h33, 9'd0);
    tests++;
    if (done !== 1'b1 || mem_w_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_done got done=%b wen=%b busy=%b exp 1 0 0", done, mem_w_en, busy);
    end
    tick;
    tests++;
    if (done !== 1'b0 || checksum !== 16'h0 || busy_seen !== 0 || wa.size() !== w0) begin
      fails++;
      $display("FAIL zero_after got done=%b cs=%h busy_seen=%0d writes=%0d exp 0 0000 0 %0d", done, checksum, busy_seen, wa.size(), w0);
    end
  endtask

  task test_wrap;
    int d0;
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    do_start(8'hFF, 9'd2);
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    push(8'hDD);
    wait_done(d0);
    tests++;
    if (wa.size() !== 2) begin
      fails++;
      $display("FAIL wrap_write_count got %0d exp 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 8'hFF || wd[0] !== 16'hBBAA || wa[1] !== 8'h00 || wd[1] !== 16'hDDCC) begin
        fails++;
        $display("FAIL wrap_writes got %h:%h %h:%h exp ff:bbaa 00:ddcc", wa[0], wd[0], wa[1], wd[1]);
      end
    end
    tests++;
    if (checksum !== 16'h6666) begin
      fails++;
      $display("FAIL wrap_checksum got %h exp 6666", checksum);
    end
  endtask

  task test_backpressure;
    logic [7:0] bytes [4];
    logic [6:0] pat;
    int i, k, d0, accepted_on_low;
    logic acc;
    bytes = '{8'h34, 8'h12, 8'h78, 8'h56};
    pat = 7'b1101001;
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    accepted_on_low = 0;
    do_start(8'h20, 9'd2);
    i = 0;
    k = 0;
    while (i < 4 && k < 60) begin
      in_valid = pat[k % 7];
      in_data = bytes[i];
      start = (k == 2 || k == 4);
      base_addr = 8'h99;
      word_count = 9'd5;
      acc = in_valid && in_ready;
      if (!in_valid && in_ready && dut.state != 2'd1) accepted_on_low++;
      tick;
      if (acc) i++;
      k++;
    end
    in_valid = 0;
    start = 0;
    wait_done(d0);
    tests++;
    if (wa.size() !== 2) begin
      fails++;
      $display("FAIL bp_write_count got %0d exp 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 8'h20 || wd[0] !== 16'h1234 || wa[1] !== 8'h21 || wd[1] !== 16'h5678) begin
        fails++;
        $display("FAIL bp_writes got %h:%h %h:%h exp 20:1234 21:5678", wa[0], wd[0], wa[1], wd[1]);
      end
    end
    tests++;
    if (checksum !== 16'h444C || done_cnt !== d0 + 1) begin
      fails++;
      $display("FAIL bp_checksum got cs=%h dones=%0d exp 444c %0d", checksum, done_cnt - d0, 1);
    end
    tick;
    tick;
    tests++;
    if (busy !== 1'b0 || done_cnt !== d0 + 1) begin
      fails++;
      $display("FAIL bp_ignored_start got busy=%b dones=%0d exp 0 1", busy, done_cnt - d0);
    end
  endtask

  task test_reset_mid;
    int d0, w0;
    w0 = wa.size();
    do_start(8'h40, 9'd1);
    push(8'hEE);
    rst = 1;
    tick;
    tests++;
    if ({in_ready, mem_w_en, busy, done} !== 4'b0 || mem_addr !== 8'h00 || mem_d_in !== 16'h0 || checksum !== 16'h0) begin
      fails++;
      $display("FAIL midreset_outputs got rdy=%b wen=%b busy=%b done=%b addr=%h d=%h cs=%h exp all zero",
               in_ready, mem_w_en, busy, done, mem_addr, mem_d_in, checksum);
    end
    rst = 0;
    tick;
    tests++;
    if (wa.size() !== w0 || mem[8'h40] !== 16'h0) begin
      fails++;
      $display("FAIL midreset_nowrite got writes=%0d mem40=%h exp %0d 0000", wa.size(), mem[8'h40], w0);
    end
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    do_start(8'h50, 9'd1);
    push(8'h01);
    push(8'h02);
    wait_done(d0);
    tests++;
    if (wa.size() !== 1) begin
      fails++;
      $display("FAIL midreset_reload_count got %0d exp 1", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 8'h50 || wd[0] !== 16'h0201 || checksum !== 16'h0201) begin
        fails++;
        $display("FAIL midreset_reload got %h:%h cs=%h exp 50:0201 0201", wa[0], wd[0], checksum);
      end
    end
  endtask

  task test_full;
    int d0, bad;
    logic [15:0] exp_cs, w;
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    exp_cs = 0;
    do_start(8'h00, 9'd256);
    for (int k = 0; k < 256; k++) begin
      w = {8'(k * 7 + 3), 8'(k)};
      exp_cs ^= w;
      push(w[7:0]);
      push(w[15:8]);
    end
    wait_done(d0);
    tick;
    tick;
    tests++;
    if (wa.size() !== 256) begin
      fails++;
      $display("FAIL full_write_count got %0d exp 256", wa.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 256; k++)
        if (wa[k] !== 8'(k) || wd[k] !== {8'(k * 7 + 3), 8'(k)}) bad++;
      tests++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL full_writes got %0d bad entries exp 0", bad);
      end
    end
    tests++;
    if (done_cnt !== d0 + 1) begin
      fails++;
      $display("FAIL full_done_pulses got %0d exp 1", done_cnt - d0);
    end
    tests++;
    if (checksum !== exp_cs) begin
      fails++;
      $display("FAIL full_checksum got %h exp %h", checksum, exp_cs);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0;
    test_reset;
    test_basic;
    test_zero;
    test_wrap;
    test_backpressure;
    test_reset_mid;
    test_full;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
